sprite_rom_arbiter: RTL and testbench

Round-robin arbiter and read sequencer that shares the single `SpriteROM` port between several sprite-line requesters, such as the player, sword, enemy and background-tile fetch units. It accepts one `(sprite_ID, orientation, line_index)` request per requester and drives the ROM read interface. It waits out the ROM read latency, then captures the 8-bit line into a per-requester holding register and signals completion with a one-cycle `done` pulse. It sits between the sprite render units and `SpriteROM`. It is the only master of the ROM's read port.

---
 rtl/sprite_rom_arbiter_if.sv | 31 +++
 rtl/sprite_rom_arbiter.sv | 126 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester and SpriteROM signal bundle for sprite_rom_arbiter
// slave is the arbiter side; master is the requester/ROM side.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_sprite_ID;
  logic [2*NUM_REQ-1:0] req_orientation;
  logic [3*NUM_REQ-1:0] req_line_index;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [8*NUM_REQ-1:0] line_data;
  logic                 busy;
  logic                 rom_read_enable;
  logic [3:0]           rom_sprite_ID;
  logic [1:0]           rom_orientation;
  logic [2:0]           rom_line_index;
  logic [7:0]           rom_data;

  modport slave (
    input  req_valid, req_sprite_ID, req_orientation, req_line_index, rom_data,
    output gnt, done, line_data, busy,
           rom_read_enable, rom_sprite_ID, rom_orientation, rom_line_index
  );

  modport master (
    output req_valid, req_sprite_ID, req_orientation, req_line_index, rom_data,
    input  gnt, done, line_data, busy,
           rom_read_enable, rom_sprite_ID, rom_orientation, rom_line_index
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter and read sequencer for the shared SpriteROM port
// One transaction in flight: IDLE select -> READ -> WAIT (ROM_LATENCY-1) -> CAPTURE -> IDLE.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sprite_rom_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [1:0] WAIT_LOAD = (ROM_LATENCY > 1) ? 2'(ROM_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_CAPTURE} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_winner;
  logic [IDX_W-1:0]     w_winner;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_found;
  logic [1:0]           r_wait_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [8*NUM_REQ-1:0] r_line_data;
  logic [3:0]           r_rom_sprite_ID;
  logic [1:0]           r_rom_orientation;
  logic [2:0]           r_rom_line_index;
  logic [3:0]           w_sel_id;
  logic [1:0]           w_sel_orient;
  logic [2:0]           w_sel_line;

  // Search starts at r_rr_ptr and wraps; first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_id     = '0;
    w_sel_orient = '0;
    w_sel_line   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_sel_id     = bus.req_sprite_ID[4*i +: 4];
        w_sel_orient = bus.req_orientation[2*i +: 2];
        w_sel_line   = bus.req_line_index[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next_state = S_READ;
      S_READ:    w_next_state = (ROM_LATENCY == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (r_wait_cnt == 2'd0) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr          <= '0;
      r_winner          <= '0;
      r_wait_cnt        <= '0;
      r_gnt             <= '0;
      r_done            <= '0;
      r_line_data       <= '0;
      r_rom_sprite_ID   <= '0;
      r_rom_orientation <= '0;
      r_rom_line_index  <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner          <= w_winner;
            r_gnt             <= NUM_REQ'(1) << w_winner;
            r_rom_sprite_ID   <= w_sel_id;
            r_rom_orientation <= w_sel_orient;
            r_rom_line_index  <= w_sel_line;
          end
        end
        S_READ: r_wait_cnt <= WAIT_LOAD;
        S_WAIT: if (r_wait_cnt != 2'd0) r_wait_cnt <= r_wait_cnt - 2'd1;
        S_CAPTURE: begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (r_winner == IDX_W'(i)) r_line_data[8*i +: 8] <= bus.rom_data;
          end
          r_done   <= NUM_REQ'(1) << r_winner;
          r_rr_ptr <= (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt             = r_gnt;
  assign bus.done            = r_done;
  assign bus.line_data       = r_line_data;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.rom_read_enable = (r_state != S_IDLE);
  assign bus.rom_sprite_ID   = r_rom_sprite_ID;
  assign bus.rom_orientation = r_rom_orientation;
  assign bus.rom_line_index  = r_rom_line_index;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed bench for sprite_rom_arbiter at ROM_LATENCY 1 and 2
// ROM models return {sprite_ID, orientation, line_index[1:0]} while read_enable is high.
module tb_sprite_rom_arbiter;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(4)) ifa ();
  sprite_rom_arbiter_if #(.NUM_REQ(4)) ifb ();

  sprite_rom_arbiter #(.NUM_REQ(4), .ROM_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  sprite_rom_arbiter #(.NUM_REQ(4), .ROM_LATENCY(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom_a_q;
  logic [7:0] rom_b_q0;
  logic [7:0] rom_b_q1;
  always @(posedge clk) begin
    rom_a_q  <= ifa.rom_read_enable ? {ifa.rom_sprite_ID, ifa.rom_orientation, ifa.rom_line_index[1:0]} : 8'h00;
    rom_b_q0 <= ifb.rom_read_enable ? {ifb.rom_sprite_ID, ifb.rom_orientation, ifb.rom_line_index[1:0]} : 8'h00;
    rom_b_q1 <= rom_b_q0;
  end
  assign ifa.rom_data = rom_a_q;
  assign ifb.rom_data = rom_b_q1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] grants [5];
  logic [3:0] g;
  logic [3:0] seen;
  int         ng;

  initial begin
    reset = 1'b1;
    ifa.req_valid = '0; ifa.req_sprite_ID = '0; ifa.req_orientation = '0; ifa.req_line_index = '0;
    ifb.req_valid = '0; ifb.req_sprite_ID = '0; ifb.req_orientation = '0; ifb.req_line_index = '0;
    tick(); tick();
    check("rst_gnt", ifa.gnt, 4'h0);
    check("rst_done", ifa.done, 4'h0);
    check("rst_line", ifa.line_data, 32'h0);
    check("rst_busy_re", {ifa.busy, ifa.rom_read_enable}, 2'b00);
    check("rst_addr", {ifa.rom_sprite_ID, ifa.rom_orientation, ifa.rom_line_index}, 9'h0);

    // single request from requester 2: id 5, orient 1, line 3
    reset = 1'b0;
    ifa.req_valid = 4'b0100;
    ifa.req_sprite_ID[11:8] = 4'd5; ifa.req_orientation[5:4] = 2'd1; ifa.req_line_index[8:6] = 3'd3;
    tick();
    check("single_gnt_c1", ifa.gnt, 4'b0100);
    check("single_busy_re_c1", {ifa.busy, ifa.rom_read_enable}, 2'b11);
    check("single_addr_c1", {ifa.rom_sprite_ID, ifa.rom_orientation, ifa.rom_line_index}, {4'd5, 2'd1, 3'd3});
    ifa.req_valid = '0;
    ifa.req_sprite_ID[11:8] = 4'hF; ifa.req_orientation[5:4] = 2'd3; ifa.req_line_index[8:6] = 3'd0;
    tick();
    check("single_gnt_done_c2", {ifa.gnt, ifa.done}, 8'h00);
    check("single_addr_c2", {ifa.rom_sprite_ID, ifa.rom_orientation, ifa.rom_line_index}, {4'd5, 2'd1, 3'd3});
    tick();
    check("single_done_c3", ifa.done, 4'b0100);
    check("single_line_c3", ifa.line_data, 32'h0057_0000);
    check("single_busy_c3", ifa.busy, 1'b0);

    // after 2 served, 1 and 3 contend: 3 first
    ifa.req_valid = 4'b1010;
    ifa.req_sprite_ID[7:4] = 4'd2;    ifa.req_orientation[3:2] = 2'd3; ifa.req_line_index[5:3] = 3'd0;
    ifa.req_sprite_ID[15:12] = 4'hC;  ifa.req_orientation[7:6] = 2'd0; ifa.req_line_index[11:9] = 3'd6;
    tick();
    check("rr_first", ifa.gnt, 4'b1000);
    ifa.req_valid = 4'b0010;
    g = '0;
    for (int i = 0; i < 10 && g == 4'h0; i++) begin
      tick();
      g = ifa.gnt;
    end
    check("rr_second", g, 4'b0010);
    ifa.req_valid = '0;
    for (int i = 0; i < 10 && ifa.busy; i++) tick();
    check("rr_line", ifa.line_data, 32'hC257_2C00);

    // continuous load from reset: grants 0,1,2,3,0
    reset = 1'b1;
    ifa.req_valid = 4'b1111;
    ifa.req_sprite_ID = {4'hF, 4'h7, 4'hA, 4'h1};
    ifa.req_orientation = {2'd1, 2'd2, 2'd3, 2'd0};
    ifa.req_line_index = {3'd4, 3'd6, 3'd5, 3'd2};
    tick();
    check("cont_rst_line", ifa.line_data, 32'h0);
    reset = 1'b0;
    tick();
    check("cont_gnt_c1", ifa.gnt, 4'b0001);
    grants[0] = ifa.gnt;
    ng = 1;
    for (int i = 0; i < 40 && ng < 5; i++) begin
      tick();
      if (ifa.gnt != 4'h0) begin
        grants[ng] = ifa.gnt;
        ng++;
      end
    end
    ifa.req_valid = '0;
    check("cont_ngrants", ng, 5);
    check("cont_g1", grants[1], 4'b0010);
    check("cont_g2", grants[2], 4'b0100);
    check("cont_g3", grants[3], 4'b1000);
    check("cont_g4", grants[4], 4'b0001);
    for (int i = 0; i < 10 && ifa.busy; i++) tick();
    check("cont_line", ifa.line_data, 32'hF47A_AD12);

    // reset during CAPTURE aborts and restarts rr_ptr at 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifa.req_valid = 4'b0100;
    ifa.req_sprite_ID[11:8] = 4'd6; ifa.req_orientation[5:4] = 2'd2; ifa.req_line_index[8:6] = 3'd1;
    tick();
    check("abort_gnt_c1", ifa.gnt, 4'b0100);
    ifa.req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_gnt_done", {ifa.gnt, ifa.done}, 8'h00);
    check("abort_line", ifa.line_data, 32'h0);
    check("abort_busy_re", {ifa.busy, ifa.rom_read_enable}, 2'b00);
    check("abort_addr", {ifa.rom_sprite_ID, ifa.rom_orientation, ifa.rom_line_index}, 9'h0);
    reset = 1'b0;
    ifa.req_valid = 4'b1010;
    tick();
    check("abort_rr_restart", ifa.gnt, 4'b0010);
    ifa.req_valid = 4'b1000;
    g = '0;
    for (int i = 0; i < 10 && g == 4'h0; i++) begin
      tick();
      g = ifa.gnt;
    end
    check("abort_rr_next", g, 4'b1000);
    ifa.req_valid = '0;
    for (int i = 0; i < 10 && ifa.busy; i++) tick();

    // ROM_LATENCY=2: requester 1, id 3, orient 2, line 1
    ifb.req_valid = 4'b0010;
    ifb.req_sprite_ID[7:4] = 4'd3; ifb.req_orientation[3:2] = 2'd2; ifb.req_line_index[5:3] = 3'd1;
    tick();
    check("l2_gnt_c1", {ifb.gnt, ifb.rom_read_enable}, {4'b0010, 1'b1});
    ifb.req_valid = '0;
    tick();
    check("l2_re_c2", {ifb.done, ifb.rom_read_enable}, {4'b0000, 1'b1});
    tick();
    check("l2_re_c3", {ifb.done, ifb.rom_read_enable}, {4'b0000, 1'b1});
    tick();
    check("l2_done_c4", {ifb.done, ifb.rom_read_enable}, {4'b0010, 1'b0});
    check("l2_line_c4", ifb.line_data, 32'h0000_3900);

    // requester 1 pulses req_valid during WAIT only: withdrawn
    ifb.req_valid = 4'b0001;
    ifb.req_sprite_ID[3:0] = 4'd9; ifb.req_orientation[1:0] = 2'd0; ifb.req_line_index[2:0] = 3'd7;
    tick();
    check("wd_gnt_c1", ifb.gnt, 4'b0001);
    ifb.req_valid = '0;
    tick();
    ifb.req_valid = 4'b0010;
    ifb.req_sprite_ID[7:4] = 4'hE;
    tick();
    ifb.req_valid = '0;
    check("wd_gnt_c3", ifb.gnt, 4'h0);
    tick();
    check("wd_done_c4", ifb.done, 4'b0001);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | ifb.gnt | ifb.done;
    end
    check("wd_no_gnt_done", seen, 4'h0);
    check("wd_line", ifb.line_data, 32'h0000_3993);
    check("wd_busy", ifb.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
